// File: rtl/mul_share_arbiter.sv
// Round-robin front-end sharing one combinational multiplicador between two
// requesters; operands and product are registered, the tagged result is held until acked.

module multiplicador #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] R,
  output logic [N-1:0] Of
);
  logic [2*N-1:0] p;

  assign p       = {{N{1'b0}}, A} * {{N{1'b0}}, B};
  assign {Of, R} = p;
endmodule

module mul_share_arbiter #(
  parameter int N    = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [N-1:0]    req_x0,
  input  logic [N-1:0]    req_y0,
  input  logic [N-1:0]    req_x1,
  input  logic [N-1:0]    req_y1,
  output logic [1:0]      req_ready,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [N-1:0]    rsp_r,
  output logic [N-1:0]    rsp_hi,
  output logic            rsp_ovf,
  input  logic            rsp_ack,
  output logic            busy,
  output logic [CNTW-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [N-1:0]    x_q, x_d, y_q, y_d;
  logic            id_q, id_d;
  logic            rsp_id_q, rsp_id_d;
  logic [N-1:0]    rsp_r_q, rsp_r_d, rsp_hi_q, rsp_hi_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic [CNTW-1:0] ops_q, ops_d;
  logic            gnt;
  logic [N-1:0]    mul_r, mul_of;

  multiplicador #(.N(N)) u_mul (
    .A  (x_q),
    .B  (y_q),
    .R  (mul_r),
    .Of (mul_of)
  );

  // ptr_q names the requester favoured when both are valid.
  assign gnt = (&req_valid) ? ptr_q : req_valid[1];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    x_d       = x_q;
    y_d       = y_q;
    id_d      = id_q;
    rsp_id_d  = rsp_id_q;
    rsp_r_d   = rsp_r_q;
    rsp_hi_d  = rsp_hi_q;
    rsp_ovf_d = rsp_ovf_q;
    ops_d     = ops_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[gnt] = 1'b1;
          x_d     = gnt ? req_x1 : req_x0;
          y_d     = gnt ? req_y1 : req_y0;
          id_d    = gnt;
          state_d = CALC;
        end
      end
      CALC: begin
        rsp_r_d   = mul_r;
        rsp_hi_d  = mul_of;
        rsp_ovf_d = |mul_of;
        rsp_id_d  = id_q;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ack) begin
          state_d = IDLE;
          ptr_d   = ~rsp_id_q;
          if (ops_q != '1) ops_d = ops_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      id_q      <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_r_q   <= '0;
      rsp_hi_q  <= '0;
      rsp_ovf_q <= 1'b0;
      ops_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      id_q      <= id_d;
      rsp_id_q  <= rsp_id_d;
      rsp_r_q   <= rsp_r_d;
      rsp_hi_q  <= rsp_hi_d;
      rsp_ovf_q <= rsp_ovf_d;
      ops_q     <= ops_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign ops_done  = ops_q;
endmodule
